// File: rtl/osmlgd_pkg.sv
// Shared sizes and FSM state encoding for the one-step majority-logic decoder.
package osmlgd_pkg;

  localparam int unsigned N  = 256;  // codeword length
  localparam int unsigned M  = 128;  // parity checks
  localparam int unsigned CW = 8;    // counter width, holds 0..M

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_SYND,
    ST_VOTE
  } state_t;

endpackage

// File: rtl/osmlgd_bitvote.sv
// Per-bit slice: counts failing checks and column weight, then votes on a flip.
module osmlgd_bitvote
  import osmlgd_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  input  logic          load,
  input  logic [M-1:0]  col,
  input  logic [M-1:0]  synd,
  output logic          flip_c
);

  logic [CW-1:0] cnt;
  logic [CW-1:0] w;
  logic [CW-1:0] cnt_c;
  logic [CW-1:0] w_c;

  // Population counts over the column: unsatisfied checks and total weight.
  always_comb begin
    cnt_c = '0;
    w_c   = '0;
    for (int unsigned j = 0; j < M; j++) begin
      cnt_c = cnt_c + CW'(col[j] & synd[j]);
      w_c   = w_c + CW'(col[j]);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
      w   <= '0;
    end else if (load) begin
      cnt <= cnt_c;
      w   <= w_c;
    end
  end

  // Strict majority 2*cnt > w at CW+1 bits; cnt <= w so w=0 can never flip.
  assign flip_c = ({cnt, 1'b0} > {1'b0, w});

endmodule

// File: rtl/osmlgd_decoder.sv
// Single-shot OSMLGD engine: latch word, register syndrome, register per-bit
// votes, then emit the corrected word with a one-cycle valid pulse.
module osmlgd_decoder
  import osmlgd_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  input  logic          work,
  input  logic [N-1:0]  tx,
  output logic          free,
  output logic [N-1:0]  deout,
  output logic          valid
);

  // Parity-check matrix, preloaded externally; no reset and no write port.
  logic [N-1:0] Harray [M];

  state_t       state;
  state_t       state_d;
  logic         free_d;
  logic         valid_d;
  logic         cw_load_c;
  logic         cnt_load_c;
  logic [N-1:0] cw_reg;
  logic [M-1:0] synd;
  logic [M-1:0] synd_c;
  logic [N-1:0] flip_c;

  // Syndrome: one XOR-AND tree per check row.
  always_comb begin
    synd_c = '0;
    for (int unsigned j = 0; j < M; j++) begin
      synd_c[j] = ^(cw_reg & Harray[j]);
    end
  end

  assign cnt_load_c = (state == ST_SYND);

  for (genvar gi = 0; gi < N; gi++) begin : g_bit
    logic [M-1:0] col_c;

    always_comb begin
      col_c = '0;
      for (int unsigned j = 0; j < M; j++) begin
        col_c[j] = Harray[j][gi];
      end
    end

    osmlgd_bitvote u_vote (
      .clk    (clk),
      .rst    (rst),
      .load   (cnt_load_c),
      .col    (col_c),
      .synd   (synd),
      .flip_c (flip_c[gi])
    );
  end

  // Next-state logic; free rises entering VOTE so a new word can be taken
  // on the same edge that completes the current one.
  always_comb begin
    state_d   = state;
    free_d    = free;
    valid_d   = 1'b0;
    cw_load_c = 1'b0;
    case (state)
      ST_IDLE: begin
        free_d = 1'b1;
        if (work) begin
          state_d   = ST_LOAD;
          free_d    = 1'b0;
          cw_load_c = 1'b1;
        end
      end
      ST_LOAD: begin
        state_d = ST_SYND;
        free_d  = 1'b0;
      end
      ST_SYND: begin
        state_d = ST_VOTE;
        free_d  = 1'b1;
      end
      ST_VOTE: begin
        valid_d = 1'b1;
        if (work) begin
          state_d   = ST_LOAD;
          free_d    = 1'b0;
          cw_load_c = 1'b1;
        end else begin
          state_d = ST_IDLE;
          free_d  = 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        free_d  = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= ST_IDLE;
      free   <= 1'b1;
      valid  <= 1'b0;
      cw_reg <= '0;
      synd   <= '0;
      deout  <= '0;
    end else begin
      state <= state_d;
      free  <= free_d;
      valid <= valid_d;
      if (cw_load_c) begin
        cw_reg <= tx;
      end
      if (state == ST_LOAD) begin
        synd <= synd_c;
      end
      if (state == ST_VOTE) begin
        deout <= cw_reg ^ flip_c;
      end
    end
  end

endmodule

// File: tb/tb_osmlgd_decoder.sv
// Directed bench for osmlgd_decoder with an expected-output queue and a
// small reference decoder over the bench's own copy of the matrix.
module tb_osmlgd_decoder;
  import osmlgd_pkg::*;

  logic         clk_tb;
  logic         rst_tb;
  logic         work_tb;
  logic [N-1:0] tx_tb;
  logic         free_tb;
  logic [N-1:0] deout_tb;
  logic         valid_tb;

  int           total;
  int           bad;
  int           vcount;
  logic [N-1:0] exp_q [$];
  logic [N-1:0] h_tb [M];

  osmlgd_decoder dut (
    .clk   (clk_tb),
    .rst   (rst_tb),
    .work  (work_tb),
    .tx    (tx_tb),
    .free  (free_tb),
    .deout (deout_tb),
    .valid (valid_tb)
  );

  initial clk_tb = 1'b0;
  always #5 clk_tb = ~clk_tb;

  // Count valid pulses away from the active edge.
  always @(negedge clk_tb) if (valid_tb === 1'b1) vcount++;

  task automatic tick();
    @(posedge clk_tb);
    #1;
  endtask

  task automatic chk(input string tag, input logic [N-1:0] got, input logic [N-1:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Compare valid/free; on a valid pulse pop the scoreboard and compare deout.
  task automatic chk_out(input string tag, input logic exp_valid, input logic exp_free);
    logic [N-1:0] e;
    chk({tag, ".valid"}, N'(valid_tb), N'(exp_valid));
    chk({tag, ".free"}, N'(free_tb), N'(exp_free));
    if (valid_tb === 1'b1) begin
      chk({tag, ".qnonempty"}, N'(exp_q.size() != 0), N'(1));
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk({tag, ".deout"}, deout_tb, e);
      end
    end
  endtask

  function automatic logic [N-1:0] rand256();
    logic [N-1:0] r;
    for (int k = 0; k < int'(N / 32); k++) r[k*32 +: 32] = $urandom;
    return r;
  endfunction

  // Reference one-step majority decode against h_tb.
  function automatic logic [N-1:0] ref_decode(input logic [N-1:0] word);
    logic [M-1:0] s;
    logic [N-1:0] f;
    int c;
    int w;
    for (int j = 0; j < int'(M); j++) s[j] = ^(word & h_tb[j]);
    for (int i = 0; i < int'(N); i++) begin
      c = 0;
      w = 0;
      for (int j = 0; j < int'(M); j++) begin
        if (h_tb[j][i]) begin
          w++;
          if (s[j]) c++;
        end
      end
      f[i] = (2 * c > w);
    end
    return word ^ f;
  endfunction

  task automatic load_h();
    for (int j = 0; j < int'(M); j++) dut.Harray[j] = h_tb[j];
  endtask

  task automatic set_k4();
    for (int j = 0; j < int'(M); j++) h_tb[j] = '0;
    h_tb[0] = N'(4'h3);
    h_tb[1] = N'(4'h5);
    h_tb[2] = N'(4'h9);
    h_tb[3] = N'(4'h6);
    h_tb[4] = N'(4'hA);
    h_tb[5] = N'(4'hC);
    load_h();
  endtask

  // One isolated decode starting from IDLE, checking every cycle to E4.
  task automatic run_decode(input string tag, input logic [N-1:0] word, input logic [N-1:0] exp);
    int v0;
    v0 = vcount;
    work_tb = 1'b1;
    tx_tb   = word;
    exp_q.push_back(exp);
    tick();
    work_tb = 1'b0;
    tx_tb   = rand256();
    chk_out({tag, "@E0"}, 1'b0, 1'b0);
    tick(); chk_out({tag, "@E1"}, 1'b0, 1'b0);
    tick(); chk_out({tag, "@E2"}, 1'b0, 1'b1);
    tick(); chk_out({tag, "@E3"}, 1'b1, 1'b1);
    tick(); chk_out({tag, "@E4"}, 1'b0, 1'b1);
    chk({tag, ".hold"}, deout_tb, exp);
    chk({tag, ".pulses"}, N'(vcount - v0), N'(1));
  endtask

  initial begin
    logic [N-1:0] w;
    int v0;
    total   = 0;
    bad     = 0;
    vcount  = 0;
    rst_tb  = 1'b0;
    work_tb = 1'b0;
    tx_tb   = '0;

    // Reset values
    tick();
    chk("rst.free", N'(free_tb), N'(1));
    chk("rst.valid", N'(valid_tb), N'(0));
    chk("rst.deout", deout_tb, '0);
    rst_tb = 1'b1;

    // Idle with work low: no valid
    v0 = vcount;
    for (int k = 0; k < 10; k++) tick();
    chk("idle.pulses", N'(vcount - v0), N'(0));
    chk("idle.free", N'(free_tb), N'(1));

    // Zero matrix passes the word through unchanged
    for (int j = 0; j < int'(M); j++) h_tb[j] = '0;
    load_h();
    w = {32{8'hA5}};
    run_decode("zero.a5", w, w);
    for (int k = 0; k < 2; k++) begin
      w = rand256();
      run_decode("zero.rand", w, w);
    end

    // K4 matrix cases
    set_k4();
    run_decode("k4.bit0", N'(4'h1), '0);
    run_decode("k4.zero", '0, '0);
    run_decode("k4.bits01", N'(4'h3), N'(4'hC));
    run_decode("k4.w0bit", N'(8'h21), N'(8'h20));
    for (int k = 0; k < 3; k++) begin
      w = rand256();
      run_decode("k4.rand", w, ref_decode(w));
    end

    // Back-to-back: work held through decode, re-accepted at E3
    v0 = vcount;
    work_tb = 1'b1;
    tx_tb   = N'(4'h1);
    exp_q.push_back('0);
    tick();
    tx_tb = rand256();
    chk_out("b2b@E0", 1'b0, 1'b0);
    tick(); chk_out("b2b@E1", 1'b0, 1'b0);
    tick(); chk_out("b2b@E2", 1'b0, 1'b1);
    tx_tb = N'(4'h3);
    exp_q.push_back(N'(4'hC));
    tick(); chk_out("b2b@E3", 1'b1, 1'b0);
    work_tb = 1'b0;
    tx_tb   = rand256();
    tick(); chk_out("b2b@E4", 1'b0, 1'b0);
    tick(); chk_out("b2b@E5", 1'b0, 1'b1);
    tick(); chk_out("b2b@E6", 1'b1, 1'b1);
    tick(); chk_out("b2b@E7", 1'b0, 1'b1);
    chk("b2b.pulses", N'(vcount - v0), N'(2));

    // Reset asserted at E2 discards the decode
    v0 = vcount;
    work_tb = 1'b1;
    tx_tb   = N'(4'h1);
    tick();
    work_tb = 1'b0;
    tick();
    tick();
    rst_tb = 1'b0;
    #1;
    chk("midrst.free", N'(free_tb), N'(1));
    chk("midrst.valid", N'(valid_tb), N'(0));
    chk("midrst.deout", deout_tb, '0);
    tick();
    rst_tb = 1'b1;
    for (int k = 0; k < 4; k++) tick();
    chk("midrst.pulses", N'(vcount - v0), N'(0));
    chk("midrst.deout2", deout_tb, '0);
    run_decode("midrst.next", N'(4'h3), N'(4'hC));

    // Random sparse matrices against the reference decoder
    for (int r = 0; r < 3; r++) begin
      for (int j = 0; j < int'(M); j++) h_tb[j] = rand256() & rand256() & rand256() & rand256();
      load_h();
      w = rand256() & rand256();
      run_decode("rnd", w, ref_decode(w));
    end

    chk("queue.empty", N'(exp_q.size()), N'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
